cop0_registers_uni: RTL and testbench

COP0_REGISTERS_UNI -- requirements
Module: cop0_registers_uni

---
 rtl/cop0_pkg.sv | 24 ++
 rtl/cop0_read_mux.sv | 24 ++
 rtl/cop0_registers_uni.sv | 112 +++++++++++
 tb/tb_cop0_registers_uni.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/cop0_pkg.sv
// Shared COP0 definitions: register indices, Status/Cause field positions, reset constants.
package cop0_pkg;

  localparam logic [4:0] REG_BADVADDR = 5'd8;
  localparam logic [4:0] REG_STATUS   = 5'd12;
  localparam logic [4:0] REG_CAUSE    = 5'd13;
  localparam logic [4:0] REG_EPC      = 5'd14;

  localparam int unsigned STATUS_IE     = 0;
  localparam int unsigned STATUS_EXL    = 1;
  localparam int unsigned STATUS_UM     = 4;
  localparam int unsigned STATUS_IM_LO  = 8;
  localparam int unsigned STATUS_IM_HI  = 15;

  localparam int unsigned CAUSE_BD      = 31;
  localparam int unsigned CAUSE_IP_LO   = 8;
  localparam int unsigned CAUSE_IP_HI   = 15;
  localparam int unsigned CAUSE_EXC_LO  = 2;
  localparam int unsigned CAUSE_EXC_HI  = 6;

  localparam logic [31:0] STATUS_RESET  = 32'h0000_FF11;
  localparam logic [31:0] STATUS_WMASK  = 32'h0000_FF13;

endpackage

// File: rtl/cop0_read_mux.sv
// Maps a COP0 register index to its 32-bit value; unimplemented indices read zero.
module cop0_read_mux
  import cop0_pkg::*;
(
  input  logic [4:0]  iIndex,
  input  logic [31:0] iBadVAddr,
  input  logic [31:0] iStatus,
  input  logic [31:0] iCause,
  input  logic [31:0] iEpc,
  output logic [31:0] oData
);

  always_comb begin
    oData = '0;
    case (iIndex)
      REG_BADVADDR: oData = iBadVAddr;
      REG_STATUS:   oData = iStatus;
      REG_CAUSE:    oData = iCause;
      REG_EPC:      oData = iEpc;
      default:      oData = '0;
    endcase
  end

endmodule

// File: rtl/cop0_registers_uni.sv
// COP0 register file (BadVAddr, Status, Cause, EPC) for a single-cycle MIPS core.
// COP0_DEBUG_PORT_EN enables the oRegDisp debug read port; otherwise it reads zero.
module cop0_registers_uni
  import cop0_pkg::*;
(
  input  logic        iCLK,
  input  logic        iRST,
  input  logic [4:0]  iReadRegister,
  input  logic [4:0]  iWriteRegister,
  input  logic [31:0] iWriteData,
  input  logic        iRegWrite,
  output logic [31:0] oReadData,
  input  logic        iEret,
  input  logic        iExcOccurred,
  input  logic        iBranchDelay,
  input  logic [7:0]  iPendingInterrupt,
  input  logic [4:0]  iExcCode,
  output logic [7:0]  oInterruptMask,
  output logic        oUserMode,
  output logic        oExcLevel,
  input  logic [4:0]  iRegDispSelect,
  output logic [31:0] oRegDisp
);

  logic [31:0] badVAddr;
  logic [31:0] status;
  logic [31:0] statusNext;
  logic [31:0] epc;
  logic        causeBd;
  logic [4:0]  causeExc;
  logic [1:0]  swIp;
  logic [7:0]  pendReg;
  logic [31:0] causeVal;
  logic [31:0] muxRead;
  logic        mtc0;

  assign mtc0 = iRegWrite && !iExcOccurred;

  // Exception beats eret; eret clears EXL even when mtc0 writes Status in the same cycle.
  always_comb begin
    statusNext = status;
    if (mtc0 && (iWriteRegister == REG_STATUS))
      statusNext = iWriteData & STATUS_WMASK;
    if (iExcOccurred)
      statusNext[STATUS_EXL] = 1'b1;
    else if (iEret)
      statusNext[STATUS_EXL] = 1'b0;
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      badVAddr <= '0;
      status   <= STATUS_RESET;
      epc      <= '0;
      causeBd  <= 1'b0;
      causeExc <= '0;
      swIp     <= '0;
      pendReg  <= '0;
    end else begin
      status  <= statusNext;
      pendReg <= iPendingInterrupt;
      if (iExcOccurred) begin
        epc      <= iWriteData;
        causeExc <= iExcCode;
        causeBd  <= iBranchDelay;
      end else if (iRegWrite) begin
        case (iWriteRegister)
          REG_BADVADDR: badVAddr <= iWriteData;
          REG_CAUSE:    swIp     <= iWriteData[CAUSE_IP_LO+1:CAUSE_IP_LO];
          REG_EPC:      epc      <= iWriteData;
          default:      ;
        endcase
      end
    end
  end

  assign causeVal = {causeBd, 15'b0, pendReg[7:2], swIp | pendReg[1:0],
                     1'b0, causeExc, 2'b0};

  cop0_read_mux readMux (
    .iIndex    (iReadRegister),
    .iBadVAddr (badVAddr),
    .iStatus   (status),
    .iCause    (causeVal),
    .iEpc      (epc),
    .oData     (muxRead)
  );

  assign oReadData = iEret ? epc : muxRead;

`ifdef COP0_DEBUG_PORT_EN
  cop0_read_mux dispMux (
    .iIndex    (iRegDispSelect),
    .iBadVAddr (badVAddr),
    .iStatus   (status),
    .iCause    (causeVal),
    .iEpc      (epc),
    .oData     (oRegDisp)
  );
`else
  logic unusedDispSel;
  assign unusedDispSel = ^iRegDispSelect;
  assign oRegDisp      = '0;
`endif

  assign oInterruptMask = (status[STATUS_IE] && !status[STATUS_EXL])
                        ? (causeVal[CAUSE_IP_HI:CAUSE_IP_LO] & status[STATUS_IM_HI:STATUS_IM_LO])
                        : '0;
  assign oUserMode = status[STATUS_UM];
  assign oExcLevel = status[STATUS_EXL];

endmodule

// File: tb/tb_cop0_registers_uni.sv
// Directed self-checking bench for cop0_registers_uni (default build, debug port disabled).
module tb_cop0_registers_uni;

  logic        iCLK = 1'b0;
  logic        iRST;
  logic [4:0]  iReadRegister;
  logic [4:0]  iWriteRegister;
  logic [31:0] iWriteData;
  logic        iRegWrite;
  logic [31:0] oReadData;
  logic        iEret;
  logic        iExcOccurred;
  logic        iBranchDelay;
  logic [7:0]  iPendingInterrupt;
  logic [4:0]  iExcCode;
  logic [7:0]  oInterruptMask;
  logic        oUserMode;
  logic        oExcLevel;
  logic [4:0]  iRegDispSelect;
  logic [31:0] oRegDisp;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  cop0_registers_uni dut (
    .iCLK              (iCLK),
    .iRST              (iRST),
    .iReadRegister     (iReadRegister),
    .iWriteRegister    (iWriteRegister),
    .iWriteData        (iWriteData),
    .iRegWrite         (iRegWrite),
    .oReadData         (oReadData),
    .iEret             (iEret),
    .iExcOccurred      (iExcOccurred),
    .iBranchDelay      (iBranchDelay),
    .iPendingInterrupt (iPendingInterrupt),
    .iExcCode          (iExcCode),
    .oInterruptMask    (oInterruptMask),
    .oUserMode         (oUserMode),
    .oExcLevel         (oExcLevel),
    .iRegDispSelect    (iRegDispSelect),
    .oRegDisp          (oRegDisp)
  );

  always #50 iCLK = ~iCLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  task automatic rd(input logic [4:0] idx, input logic [31:0] exp, input string tag);
    iReadRegister = idx;
    #1;
    check(tag, oReadData, exp);
  endtask

  task automatic mtc0(input logic [4:0] idx, input logic [31:0] data);
    iRegWrite      = 1'b1;
    iWriteRegister = idx;
    iWriteData     = data;
    tick();
    iRegWrite      = 1'b0;
  endtask

  initial begin
    iRST = 1'b1; iReadRegister = '0; iWriteRegister = '0; iWriteData = '0;
    iRegWrite = 1'b0; iEret = 1'b0; iExcOccurred = 1'b0; iBranchDelay = 1'b0;
    iPendingInterrupt = '0; iExcCode = '0; iRegDispSelect = 5'd12;
    tick();
    tick();
    iRST = 1'b0;

    // Reset state
    rd(5'd12, 32'h0000FF11, "rst_status");
    rd(5'd13, 32'h0, "rst_cause");
    rd(5'd14, 32'h0, "rst_epc");
    rd(5'd8,  32'h0, "rst_badv");
    check("rst_um",  {31'b0, oUserMode}, 32'd1);
    check("rst_exl", {31'b0, oExcLevel}, 32'd0);
    check("regdisp_tied", oRegDisp, 32'h0);

    // Hardware interrupt line enabled by reset Status
    iPendingInterrupt = 8'h04;
    tick();
    check("imask_hw", {24'b0, oInterruptMask}, 32'h04);
    rd(5'd13, 32'h00000400, "cause_ip_hw");

    // Clearing IM masks it off
    mtc0(5'd12, 32'h00000011);
    rd(5'd12, 32'h00000011, "status_wr");
    check("imask_masked", {24'b0, oInterruptMask}, 32'h00);

    // Only writable Status bits stick
    mtc0(5'd12, 32'hFFFFFFFF);
    rd(5'd12, 32'h0000FF13, "status_wmask");
    check("imask_exl", {24'b0, oInterruptMask}, 32'h00);
    mtc0(5'd12, 32'h0000FF01);
    check("um_cleared", {31'b0, oUserMode}, 32'd0);
    check("imask_ie", {24'b0, oInterruptMask}, 32'h04);

    // Software interrupt bits OR with hardware lines
    mtc0(5'd13, 32'hFFFFFFFF);
    rd(5'd13, 32'h00000700, "cause_swip");
    check("imask_sw", {24'b0, oInterruptMask}, 32'h07);
    mtc0(5'd8, 32'h12345678);
    rd(5'd8, 32'h12345678, "badv_wr");
    mtc0(5'd5, 32'hFFFFFFFF);
    rd(5'd5, 32'h0, "unimpl_idx");
    iPendingInterrupt = 8'h00;
    mtc0(5'd13, 32'h0);
    rd(5'd13, 32'h0, "cause_clr");

    // Exception entry
    iExcOccurred = 1'b1; iWriteData = 32'h00400010; iExcCode = 5'd12; iBranchDelay = 1'b1;
    tick();
    iExcOccurred = 1'b0; iBranchDelay = 1'b0;
    rd(5'd14, 32'h00400010, "exc_epc");
    rd(5'd13, 32'h80000030, "exc_cause");
    check("exc_exl", {31'b0, oExcLevel}, 32'd1);
    check("exc_imask", {24'b0, oInterruptMask}, 32'h00);
    iPendingInterrupt = 8'h04;
    tick();
    rd(5'd13, 32'h80000430, "exc_cause_ip");
    check("exc_imask_pend", {24'b0, oInterruptMask}, 32'h00);

    // Eret overrides read index and clears EXL despite simultaneous Status write
    iReadRegister = 5'd0;
    iEret = 1'b1;
    iRegWrite = 1'b1; iWriteRegister = 5'd12; iWriteData = 32'h0000FF13;
    #1;
    check("eret_read", oReadData, 32'h00400010);
    tick();
    iEret = 1'b0; iRegWrite = 1'b0;
    rd(5'd12, 32'h0000FF11, "eret_status");
    check("eret_exl", {31'b0, oExcLevel}, 32'd0);
    check("eret_imask", {24'b0, oInterruptMask}, 32'h04);

    // Exception suppresses simultaneous mtc0 and eret
    iExcOccurred = 1'b1; iEret = 1'b1; iRegWrite = 1'b1; iWriteRegister = 5'd8;
    iWriteData = 32'hDEADBEEF; iExcCode = 5'd4; iBranchDelay = 1'b0;
    tick();
    iExcOccurred = 1'b0; iEret = 1'b0; iRegWrite = 1'b0;
    rd(5'd14, 32'hDEADBEEF, "excw_epc");
    rd(5'd8,  32'h12345678, "excw_badv");
    rd(5'd13, 32'h00000410, "excw_cause");
    rd(5'd12, 32'h0000FF13, "excw_status");

    // Exception with mtc0 to EPC: exception path supplies the value
    iExcOccurred = 1'b1; iRegWrite = 1'b1; iWriteRegister = 5'd14;
    iWriteData = 32'hDEADBEEF; iExcCode = 5'd8; iBranchDelay = 1'b1;
    tick();
    iExcOccurred = 1'b0; iRegWrite = 1'b0; iBranchDelay = 1'b0;
    rd(5'd14, 32'hDEADBEEF, "exc14_epc");
    rd(5'd13, 32'h80000420, "exc14_cause");

    // Reset dominates active inputs
    iRST = 1'b1; iExcOccurred = 1'b1; iRegWrite = 1'b1; iWriteRegister = 5'd14;
    iWriteData = 32'hCAFEF00D;
    tick();
    iRST = 1'b0; iExcOccurred = 1'b0; iRegWrite = 1'b0;
    rd(5'd12, 32'h0000FF11, "rst2_status");
    rd(5'd13, 32'h0, "rst2_cause");
    rd(5'd14, 32'h0, "rst2_epc");
    rd(5'd8,  32'h0, "rst2_badv");
    check("rst2_exl", {31'b0, oExcLevel}, 32'd0);
    check("rst2_um",  {31'b0, oUserMode}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
